aer_ravens_roi_bridge: RTL and testbench

//  Parametrised next-generation DVS AER receiver -> RAVENS spike packet bridge.
//  - Performs the 4-phase AER handshake with the camera: Y word, then one or more X words.
//  - Maps pixels inside a configurable region of interest (ROI) to neuron IDs.
//  - Optional downsampling and polarity routing.
//  - Buffers packets in a FIFO with a valid/ready output handshake.
//  - Sits between the DVS camera pins and the RAVENS spike-input port.

---
 rtl/aer_ravens_roi_bridge_if.sv | 28 ++
 rtl/aer_ravens_roi_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_aer_ravens_roi_bridge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/aer_ravens_roi_bridge_if.sv
// Purpose : bundles the camera-side AER handshake and the RAVENS packet stream of the bridge.
// Latency : n/a (signal bundle only).
// Backpr. : pkt_valid/pkt_ready on the packet side, 4-phase req/ack on the camera side.
// Ports   : aer[9:0], xsel, req (camera -> bridge); ack (bridge -> camera);
//           ravens_pkt, pkt_valid, drop_cnt (bridge -> consumer); pkt_ready (consumer -> bridge).
//           master = camera/consumer side, slave = the bridge.
interface aer_ravens_roi_bridge_if #(
  parameter int PKT_BITS = 32
);
  logic [9:0]          aer;
  logic                xsel;
  logic                req;
  logic                ack;
  logic [PKT_BITS-1:0] ravens_pkt;
  logic                pkt_valid;
  logic                pkt_ready;
  logic [15:0]         drop_cnt;

  modport master (
    output aer, xsel, req, pkt_ready,
    input  ack, ravens_pkt, pkt_valid, drop_cnt
  );

  modport slave (
    input  aer, xsel, req, pkt_ready,
    output ack, ravens_pkt, pkt_valid, drop_cnt
  );
endinterface

// File: rtl/aer_ravens_roi_bridge.sv
// Purpose : DVS AER receiver -> RAVENS spike bridge with ROI mapping, downsampling, polarity routing,
//           duplicate suppression and an output FIFO.
// Latency : req edge -> ack high = 2 + SETTLE_CYCLES + 2 cycles; packet visible together with ack.
// Backpr. : FIFO drains on pkt_valid&&pkt_ready; pushes into a full FIFO (without same-cycle pop)
//           are dropped and counted in drop_cnt (saturating). The camera is never stalled.
// Ports   : i_clk, i_rst (sync, active-high); io_bus (slave modport of aer_ravens_roi_bridge_if).
module aer_ravens_roi_bridge #(
  parameter int unsigned PKT_BITS      = 32,
  parameter int unsigned NEURON_BITS   = 8,
  parameter int unsigned ROI_X0        = 0,
  parameter int unsigned ROI_Y0        = 0,
  parameter int unsigned ROI_W         = 100,
  parameter int unsigned ROI_H         = 100,
  parameter int unsigned DS_SHIFT      = 0,
  parameter int unsigned POL_MODE      = 1,
  parameter int unsigned POL_OFFSET    = 128,
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  aer_ravens_roi_bridge_if.slave  io_bus
);

  // ---------------------------------------------------------------- constants
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned X_HI   = ROI_X0 + ROI_W;
  localparam int unsigned Y_HI   = ROI_Y0 + ROI_H;
  localparam int unsigned STRIDE = ROI_W >> DS_SHIFT;
  localparam int unsigned PAD    = PKT_BITS - NEURON_BITS - 5;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]      FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- state
  logic                   r_req_meta;
  logic                   r_req_s;
  logic [2:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ack;
  logic [8:0]             r_y;
  logic                   r_y_valid;
  logic [NEURON_BITS-1:0] r_last_id;
  logic                   r_last_id_valid;
  logic [15:0]            r_drop_cnt;

  logic [PKT_BITS-1:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;

  // ---------------------------------------------------------------- X-word evaluation
  logic [8:0]             w_x;
  logic                   w_pol;
  logic [31:0]            w_x32;
  logic [31:0]            w_y32;
  logic [31:0]            w_dx;
  logic [31:0]            w_dy;
  logic [31:0]            w_id32;
  logic [NEURON_BITS-1:0] w_id;
  logic [PKT_BITS-1:0]    w_pkt;
  logic                   w_in_roi;
  logic                   w_pol_ok;
  logic                   w_dup;
  logic                   w_want;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  assign w_x   = io_bus.aer[9:1];
  assign w_pol = io_bus.aer[0];
  assign w_x32 = {23'd0, w_x};
  assign w_y32 = {23'd0, r_y};

  assign w_in_roi = (w_x32 >= ROI_X0) && (w_x32 < X_HI) &&
                    (w_y32 >= ROI_Y0) && (w_y32 < Y_HI);

  always_comb begin
    w_pol_ok = 1'b1;
    case (POL_MODE)
      1:       w_pol_ok = w_pol;
      2:       w_pol_ok = ~w_pol;
      default: w_pol_ok = 1'b1;
    endcase
  end

  // Offsets are only meaningful once the ROI test passes; out-of-ROI wraparound is harmless.
  assign w_dx   = (w_x32 - ROI_X0) >> DS_SHIFT;
  assign w_dy   = (w_y32 - ROI_Y0) >> DS_SHIFT;
  assign w_id32 = (w_dy * STRIDE) + w_dx +
                  (((POL_MODE == 3) && !w_pol) ? POL_OFFSET : 32'd0);
  assign w_id   = w_id32[NEURON_BITS-1:0];
  assign w_pkt  = {{PAD{1'b0}}, w_id, 5'd0};

  assign w_dup  = r_last_id_valid && (w_id == r_last_id);
  assign w_want = (r_state == ST_CAPTURE) && io_bus.xsel && r_y_valid &&
                  w_in_roi && w_pol_ok && !w_dup;

  // ---------------------------------------------------------------- FIFO control
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FIFO_FULL);
  assign w_pop   = io_bus.pkt_ready && !w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = w_want && (!w_full || w_pop);
  assign w_drop  = w_want && w_full && !w_pop;

  // ---------------------------------------------------------------- req synchronizer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_req_meta <= 1'b0;
      r_req_s    <= 1'b0;
    end else begin
      r_req_meta <= io_bus.req;
      r_req_s    <= r_req_meta;
    end
  end

  // ---------------------------------------------------------------- handshake FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ack     <= 1'b0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_req_s) begin
            r_state <= ST_SETTLE;
            r_cnt   <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          // Bus has been stable for the settle window; sample it exactly once.
          if (!io_bus.xsel) begin
            r_y       <= io_bus.aer[8:0];
            r_y_valid <= 1'b1;
          end
          r_ack   <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          if (!r_req_s) begin
            r_ack   <= 1'b0;
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // One extra cycle guarantees ack low is registered before req is sensed again.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- duplicate tracker / drops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_id       <= '0;
      r_last_id_valid <= 1'b0;
      r_drop_cnt      <= '0;
    end else begin
      if (w_push) begin
        r_last_id       <= w_id;
        r_last_id_valid <= 1'b1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------- FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_pkt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign io_bus.ack        = r_ack;
  assign io_bus.pkt_valid  = !w_empty;
  assign io_bus.ravens_pkt = w_empty ? '0 : r_mem[r_rd_ptr];
  assign io_bus.drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_aer_ravens_roi_bridge.sv
// Directed bench: dut_a uses default parameters, dut_b uses DS_SHIFT=1 / POL_MODE=3.
// Both share the camera stimulus; dut_b is held in reset until its own scenario.
module tb_aer_ravens_roi_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_b = 1'b1;
  logic [9:0] aer = '0;
  logic       xsel = 1'b0;
  logic       req = 1'b0;
  logic       ready_a = 1'b0;
  logic       ready_b = 1'b0;

  int tests = 0;
  int fails = 0;
  int ack_rises = 0;
  logic ack_prev = 1'b0;

  logic        v_ack;
  logic [31:0] p_ack;

  always #5 clk = ~clk;

  aer_ravens_roi_bridge_if #(.PKT_BITS(32)) bus_a ();
  aer_ravens_roi_bridge_if #(.PKT_BITS(32)) bus_b ();

  assign bus_a.aer = aer;
  assign bus_a.xsel = xsel;
  assign bus_a.req = req;
  assign bus_a.pkt_ready = ready_a;
  assign bus_b.aer = aer;
  assign bus_b.xsel = xsel;
  assign bus_b.req = req;
  assign bus_b.pkt_ready = ready_b;

  aer_ravens_roi_bridge dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus_a)
  );

  aer_ravens_roi_bridge #(.DS_SHIFT(1), .POL_MODE(3)) dut_b (
    .i_clk  (clk),
    .i_rst  (rst_b),
    .io_bus (bus_b)
  );

  always @(posedge clk) begin
    ack_prev <= bus_a.ack;
    if (bus_a.ack && !ack_prev) ack_rises <= ack_rises + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One full 4-phase word; reports pkt_valid/ravens_pkt of dut_a at the moment ack is seen.
  task automatic send(input logic xs, input logic [9:0] d,
                      output logic v_at_ack, output logic [31:0] p_at_ack);
    int n;
    aer = d;
    xsel = xs;
    req = 1'b1;
    n = 0;
    while (bus_a.ack !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check("ack_latency", 32'(n), 32'd9);
    v_at_ack = bus_a.pkt_valid;
    p_at_ack = bus_a.ravens_pkt;
    req = 1'b0;
    n = 0;
    while (bus_a.ack !== 1'b0 && n < 20) begin
      cyc();
      n++;
    end
    check("ack_release", 32'(bus_a.ack), 32'd0);
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset
    rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    check("rst_ack", 32'(bus_a.ack), 32'd0);
    check("rst_valid", 32'(bus_a.pkt_valid), 32'd0);
    check("rst_pkt", bus_a.ravens_pkt, 32'd0);
    check("rst_drop", 32'(bus_a.drop_cnt), 32'd0);
    cyc();

    // ---------------- 1: Y=3, X=7 pol=1 -> 0x660
    send(1'b0, 10'h003, v_ack, p_ack);
    check("t1_y_no_pkt", 32'(v_ack), 32'd0);
    send(1'b1, 10'h00F, v_ack, p_ack);
    check("t1_valid_with_ack", 32'(v_ack), 32'd1);
    check("t1_pkt_at_ack", p_ack, 32'h0000_0660);
    check("t1_pkt_held", bus_a.ravens_pkt, 32'h0000_0660);
    check("t1_ack_pulses", 32'(ack_rises), 32'd2);
    ready_a = 1'b1;
    cyc();
    ready_a = 1'b0;
    check("t1_popped_valid", 32'(bus_a.pkt_valid), 32'd0);
    check("t1_popped_pkt", bus_a.ravens_pkt, 32'd0);

    // ---------------- 2: duplicate suppression, ready=1
    ready_a = 1'b1;
    send(1'b1, 10'h013, v_ack, p_ack);           // X=9 -> id 309%256=0x35
    check("t2_first_pkt", p_ack, 32'h0000_06A0);
    send(1'b1, 10'h013, v_ack, p_ack);           // same event again
    check("t2_dup_suppressed", 32'(v_ack), 32'd0);
    send(1'b1, 10'h011, v_ack, p_ack);           // X=8 -> 0x34
    check("t2_x8_pkt", p_ack, 32'h0000_0680);

    // ---------------- 3: polarity filter and out-of-ROI
    send(1'b1, 10'h00E, v_ack, p_ack);           // X=7 pol=0
    check("t3_off_filtered", 32'(v_ack), 32'd0);
    send(1'b1, 10'h12D, v_ack, p_ack);           // X=150 pol=1
    check("t3_outside_roi", 32'(v_ack), 32'd0);
    check("t3_no_drop", 32'(bus_a.drop_cnt), 32'd0);

    // ---------------- 4: fill FIFO, one drop, drain in order
    ready_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      send(1'b1, {9'(10 + k), 1'b1}, v_ack, p_ack);
    end
    check("t4_valid", 32'(bus_a.pkt_valid), 32'd1);
    check("t4_drop_cnt", 32'(bus_a.drop_cnt), 32'd1);
    ready_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t4_pop_order", bus_a.ravens_pkt, (32'h36 + 32'(k)) << 5);
      cyc();
    end
    check("t4_drained", 32'(bus_a.pkt_valid), 32'd0);

    // ---------------- 5: dut_b, DS_SHIFT=1, POL_MODE=3
    rst_b = 1'b0;
    cyc();
    send(1'b0, 10'h003, v_ack, p_ack);
    send(1'b1, 10'h00F, v_ack, p_ack);
    check("t5_b_valid", 32'(bus_b.pkt_valid), 32'd1);
    check("t5_b_on_pkt", bus_b.ravens_pkt, 32'h0000_06A0);
    send(1'b1, 10'h00E, v_ack, p_ack);
    ready_b = 1'b1;
    cyc();
    check("t5_b_off_pkt", bus_b.ravens_pkt, 32'h0000_16A0);
    cyc();
    ready_b = 1'b0;
    check("t5_b_drained", 32'(bus_b.pkt_valid), 32'd0);

    // ---------------- 6: reset mid-handshake with packets queued
    ready_a = 1'b0;
    send(1'b1, 10'h029, v_ack, p_ack);           // X=20 -> 0x800
    send(1'b1, 10'h02B, v_ack, p_ack);           // X=21 -> 0x820
    check("t6_queued_head", bus_a.ravens_pkt, 32'h0000_0800);
    aer = 10'h02D;
    xsel = 1'b1;
    req = 1'b1;
    for (int n = 0; n < 40 && bus_a.ack !== 1'b1; n++) cyc();
    check("t6_ack_before_rst", 32'(bus_a.ack), 32'd1);
    rst = 1'b1;
    req = 1'b0;
    cyc();
    rst = 1'b0;
    check("t6_rst_ack", 32'(bus_a.ack), 32'd0);
    check("t6_rst_valid", 32'(bus_a.pkt_valid), 32'd0);
    check("t6_rst_drop", 32'(bus_a.drop_cnt), 32'd0);
    cyc(); cyc(); cyc(); cyc();
    send(1'b1, 10'h02D, v_ack, p_ack);           // X=22 with no Y since reset
    check("t6_no_y_no_pkt", 32'(v_ack), 32'd0);
    check("t6_still_empty", 32'(bus_a.pkt_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
